sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter.sv | 89 ++++++++
 tb/tb_sram_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one async SRAM between a write port and a read port
module sram_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);
  localparam int W = WAIT_CYCLES < 1 ? 1 : WAIT_CYCLES > 7 ? 7 : WAIT_CYCLES;
  typedef enum logic [2:0] {IDLE, WR, WR_HOLD, RD, RD_DONE} state_t;
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic last_wr, grant_wr, grant_rd, dq_oe, sel;
  logic [DATA_W-1:0] wdata;
  assign io_SRAM_DQ = dq_oe ? wdata : 'z;
  always_comb begin
    grant_wr = i_wr_req && (!i_rd_req || !last_wr);
    grant_rd = i_rd_req && !grant_wr;
    state_nx = state;
    cnt_nx = cnt - 3'd1;
    case (state)
      IDLE: begin
        state_nx = grant_wr ? WR : grant_rd ? RD : IDLE;
        cnt_nx = grant_wr ? 3'(W - 1) : 3'(W);
      end
      WR:      state_nx = cnt == 3'd0 ? WR_HOLD : WR;
      WR_HOLD: state_nx = IDLE;
      RD:      state_nx = cnt == 3'd0 ? RD_DONE : RD;
      RD_DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    sel = state_nx == WR || state_nx == WR_HOLD || state_nx == RD;
  end
  // Every output is registered from the next state so strobes change cleanly on the clock edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      last_wr <= 1'b0;
      wdata <= '0;
      dq_oe <= 1'b0;
      o_SRAM_ADDR <= '0;
      o_rd_data <= '0;
      o_wr_ack <= 1'b0;
      o_rd_valid <= 1'b0;
      o_busy <= 1'b0;
      o_SRAM_WE_N <= 1'b1;
      o_SRAM_CE_N <= 1'b1;
      o_SRAM_OE_N <= 1'b1;
      o_SRAM_LB_N <= 1'b1;
      o_SRAM_UB_N <= 1'b1;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (state == IDLE && (grant_wr || grant_rd)) begin
        last_wr <= grant_wr;
        o_SRAM_ADDR <= grant_wr ? i_wr_addr : i_rd_addr;
        if (grant_wr) wdata <= i_wr_data;
      end
      if (state == RD && cnt == 3'd0) o_rd_data <= io_SRAM_DQ;
      dq_oe <= state_nx == WR || state_nx == WR_HOLD;
      o_wr_ack <= state_nx == WR_HOLD;
      o_rd_valid <= state_nx == RD_DONE;
      o_busy <= state_nx != IDLE;
      o_SRAM_WE_N <= state_nx != WR;
      o_SRAM_OE_N <= state_nx != RD;
      o_SRAM_CE_N <= !sel;
      o_SRAM_LB_N <= !sel;
      o_SRAM_UB_N <= !sel;
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: two harnesses (1 and 3 wait states) with SRAM model, scoreboard and random traffic
module tb_sram_arbiter;
  logic clk = 0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL h%0d %s: got %0h want %0h", g, name, act, req);
    end
  endtask
  typedef struct {
    bit          wr;
    logic [19:0] addr;
    logic [15:0] data;
  } item_t;
  for (genvar g = 0; g < 2; g++) begin : h
    localparam int WC = g ? 3 : 1;
    logic rst = 1, wr_req = 0, rd_req = 0;
    logic [19:0] wr_addr = 0, rd_addr = 0, sa;
    logic [15:0] wr_data = 0, rd_data;
    logic wr_ack, rd_valid, busy, we_n, ce_n, oe_n, lb_n, ub_n;
    wire [15:0] dq;
    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    logic [19:0] wlist [$];
    item_t sb [$];
    bit mlast = 0, done = 0;
    int we_lo = 0, oe_lo = 0;
    sram_arbiter #(.WAIT_CYCLES(WC)) u (
      .i_clk(clk), .i_rst(rst),
      .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
      .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
      .o_busy(busy), .o_SRAM_ADDR(sa), .io_SRAM_DQ(dq),
      .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n),
      .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
    );
    assign dq = (!ce_n && !oe_n && we_n) ? mem[sa[7:0]] : 'z;
    always @(negedge clk) if (!ce_n && !we_n) mem[sa[7:0]] = dq;
    always @(negedge clk) begin
      item_t e;
      if (rst) begin
        we_lo = 0;
        oe_lo = 0;
      end else begin
        if (!we_n) we_lo++;
        if (!oe_n) begin
          oe_lo++;
          chk("dq_driven_during_oe", g, 32'(u.dq_oe), 0);
        end
        if (wr_ack || rd_valid) begin
          if (sb.size() == 0) chk("unexpected_pulse", g, {wr_ack, rd_valid}, 0);
          else begin
            e = sb.pop_front();
            chk("grant_kind", g, 32'(wr_ack), 32'(e.wr));
            chk("addr", g, sa, e.addr);
            if (wr_ack) begin
              chk("mem", g, mem[e.addr[7:0]], e.data);
              chk("we_cycles", g, we_lo, WC);
            end else begin
              chk("rd_data", g, rd_data, e.data);
              chk("oe_cycles", g, oe_lo, WC + 1);
              chk("rd_done_strobes", g, {ce_n, oe_n, we_n}, 3'b111);
            end
          end
          we_lo = 0;
          oe_lo = 0;
        end
      end
    end
    task automatic exp_wr(input logic [19:0] a, input logic [15:0] d);
      sb.push_back('{1'b1, a, d});
      ref_mem[a[7:0]] = d;
      wlist.push_back(a);
    endtask
    task automatic exp_rd(input logic [19:0] a);
      sb.push_back('{1'b0, a, ref_mem[a[7:0]]});
    endtask
    task automatic access(input bit wr, input logic [19:0] a, input logic [15:0] d, input int lat, input int drop_at);
      int n;
      bit seen;
      n = 0;
      seen = 0;
      if (wr) begin
        wr_req = 1;
        wr_addr = a;
        wr_data = d;
      end else begin
        rd_req = 1;
        rd_addr = a;
      end
      do begin
        @(negedge clk);
        n++;
        if (n == drop_at) wr_req = 0;
        seen = wr ? wr_ack : rd_valid;
      end while (!seen && n < 64);
      if (wr) wr_req = 0;
      else rd_req = 0;
      if (!seen) chk("timeout", g, 32'(seen), 1);
      else if (lat != 0) chk("latency", g, n, lat);
    endtask
    initial begin
      logic [19:0] a, ra;
      logic [15:0] d;
      int op;
      repeat (3) @(negedge clk);
      chk("reset_outputs", g, {wr_ack, rd_valid, busy, we_n, ce_n, oe_n, lb_n, ub_n}, 8'b00011111);
      chk("reset_rd_data", g, rd_data, 0);
      chk("reset_addr", g, sa, 0);
      rst = 0;
      exp_wr(20'h00010, 16'hA5A5);
      access(1, 20'h00010, 16'hA5A5, WC + 1, 0);
      @(negedge clk);
      exp_rd(20'h00010);
      access(0, 20'h00010, 16'h0, WC + 2, 0);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      exp_wr(20'h00100, 16'h1111);
      exp_rd(20'h00100);
      exp_wr(20'h00200, 16'h2222);
      exp_rd(20'h00200);
      fork
        begin
          access(1, 20'h00100, 16'h1111, WC + 1, 0);
          access(1, 20'h00200, 16'h2222, 0, 0);
        end
        begin
          access(0, 20'h00100, 16'h0, 0, 0);
          access(0, 20'h00200, 16'h0, 0, 0);
        end
      join
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        exp_wr(20'(i), 16'(16'hC000 + i));
        access(1, 20'(i), 16'(16'hC000 + i), i > 0 ? WC + 2 : WC + 1, 0);
      end
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        exp_rd(20'(i));
        access(0, 20'(i), 16'h0, i > 0 ? WC + 3 : WC + 2, 0);
      end
      @(negedge clk);
      rd_req = 1;
      rd_addr = 20'h3;
      repeat (2) @(negedge clk);
      rst = 1;
      rd_req = 0;
      @(negedge clk);
      chk("abort_state", g, {rd_valid, busy, we_n, ce_n, oe_n, lb_n, ub_n, u.dq_oe}, 8'b00111110);
      @(negedge clk);
      rst = 0;
      repeat (4) @(negedge clk);
      exp_rd(20'h3);
      access(0, 20'h3, 16'h0, WC + 2, 0);
      @(negedge clk);
      exp_wr(20'h00ABC, 16'h5A5A);
      access(1, 20'h00ABC, 16'h5A5A, WC + 1, 1);
      @(negedge clk);
      exp_rd(20'h00ABC);
      access(0, 20'h00ABC, 16'h0, WC + 2, 0);
      mlast = 0;
      repeat (40) begin
        op = $urandom_range(0, 2);
        a = 20'($urandom);
        d = 16'($urandom);
        ra = wlist[$urandom_range(0, wlist.size() - 1)];
        @(negedge clk);
        if (op == 0) begin
          exp_wr(a, d);
          access(1, a, d, WC + 1, 0);
          mlast = 1;
        end else if (op == 1) begin
          exp_rd(ra);
          access(0, ra, 16'h0, WC + 2, 0);
          mlast = 0;
        end else begin
          if (!mlast) begin
            exp_wr(a, d);
            exp_rd(ra);
          end else begin
            exp_rd(ra);
            exp_wr(a, d);
          end
          fork
            access(1, a, d, 0, 0);
            access(0, ra, 16'h0, 0, 0);
          join
        end
      end
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", g, sb.size(), 0);
      done = 1;
    end
  end
  initial begin
    fork
      wait (h[0].done && h[1].done);
      #500000;
    join_any
    chk("global_timeout", 0, 32'(h[0].done && h[1].done), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
